// File: rtl/pcm_packetizer.sv
// rtl/pcm_packetizer.sv - PCM snapshot to ping-pong frame-buffer packetizer
// Optional feature macro: PCM_PACKETIZER_SEQ_EN (16-bit little-endian packet sequence number).
module pcm_packetizer #(
    parameter int CHANNELS  = 12,
    parameter int SAMPLE_W  = 16,
    parameter int FRAMES    = 32,
    parameter int HDR_BYTES = 14,
    parameter int ADDR_W    = 11
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         pcm_stb,
    input  logic [CHANNELS*SAMPLE_W-1:0] pcm_data,
    input  logic                         tx_busy,
    input  logic                         clr_flags,
    output logic                         wr_en,
    output logic [ADDR_W-1:0]            wr_addr,
    output logic [7:0]                   wr_data,
    output logic                         tx_start,
    output logic                         tx_bank,
    output logic [ADDR_W-2:0]            tx_len,
    output logic                         overrun,
    output logic                         stb_miss
);
    localparam int BPS         = SAMPLE_W / 8;
    localparam int FRAME_BYTES = CHANNELS * BPS;
`ifdef PCM_PACKETIZER_SEQ_EN
    localparam int SEQ_BYTES   = 2;
`else
    localparam int SEQ_BYTES   = 0;
`endif
    localparam int TX_LEN      = HDR_BYTES + SEQ_BYTES + FRAMES * FRAME_BYTES;
    localparam int OFF_W       = ADDR_W - 1;
    localparam int IDX_W       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int FC_W        = (FRAMES > 1) ? $clog2(FRAMES) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(FRAME_BYTES - 1);
    localparam logic [FC_W-1:0]  FRAME_LAST = FC_W'(FRAMES - 1);

    if (TX_LEN > (1 << OFF_W)) begin : g_len_check
        $error("pcm_packetizer: packet length %0d exceeds bank size %0d", TX_LEN, 1 << OFF_W);
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef PCM_PACKETIZER_SEQ_EN
        SEQ  = 2'd1,
`endif
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [CHANNELS*SAMPLE_W-1:0]   snap_q;
    logic [IDX_W-1:0]               idx_q;
    logic [FC_W-1:0]                frame_q;
    logic                           fill_bank_q;
    logic [OFF_W-1:0]               offset;
    logic [7:0]                     data_byte;
`ifdef PCM_PACKETIZER_SEQ_EN
    logic [15:0]                    seq_q;
`endif

    assign tx_len = OFF_W'(TX_LEN);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (pcm_stb) begin
`ifdef PCM_PACKETIZER_SEQ_EN
                    state_d = (frame_q == '0) ? SEQ : DATA;
`else
                    state_d = DATA;
`endif
                end
            end
`ifdef PCM_PACKETIZER_SEQ_EN
            SEQ:  if (idx_q[0]) state_d = DATA;
`endif
            DATA: if (idx_q == IDX_LAST) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sample byte idx of the snapshot is channel idx/B, byte idx%B: a flat byte index.
    always_comb begin
        offset    = OFF_W'(HDR_BYTES + SEQ_BYTES) + OFF_W'(frame_q) * OFF_W'(FRAME_BYTES)
                  + OFF_W'(idx_q);
        data_byte = snap_q[{idx_q, 3'b000} +: 8];
        wr_en     = (state_q == DATA);
`ifdef PCM_PACKETIZER_SEQ_EN
        if (state_q == SEQ) begin
            wr_en     = 1'b1;
            offset    = OFF_W'(HDR_BYTES) + OFF_W'(idx_q);
            data_byte = idx_q[0] ? seq_q[15:8] : seq_q[7:0];
        end
`endif
        wr_addr = wr_en ? {fill_bank_q, offset} : '0;
        wr_data = wr_en ? data_byte : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            idx_q       <= '0;
            frame_q     <= '0;
            fill_bank_q <= 1'b0;
            tx_start    <= 1'b0;
            tx_bank     <= 1'b0;
            overrun     <= 1'b0;
            stb_miss    <= 1'b0;
`ifdef PCM_PACKETIZER_SEQ_EN
            seq_q       <= '0;
`endif
        end else begin
            state_q  <= state_d;
            tx_start <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pcm_stb) begin
                        snap_q <= pcm_data;
                        idx_q  <= '0;
                    end
                end
`ifdef PCM_PACKETIZER_SEQ_EN
                SEQ:  idx_q <= idx_q[0] ? '0 : idx_q + IDX_W'(1);
`endif
                DATA: idx_q <= idx_q + IDX_W'(1);
                DONE: begin
                    if (frame_q == FRAME_LAST) begin
                        frame_q <= '0;
`ifdef PCM_PACKETIZER_SEQ_EN
                        seq_q   <= seq_q + 16'd1;
`endif
                        // A busy transmitter keeps the fill bank, so this packet is overwritten.
                        if (!tx_busy) begin
                            tx_start    <= 1'b1;
                            tx_bank     <= fill_bank_q;
                            fill_bank_q <= ~fill_bank_q;
                        end
                    end else begin
                        frame_q <= frame_q + FC_W'(1);
                    end
                end
                default: ;
            endcase

            if (clr_flags) begin
                overrun  <= 1'b0;
                stb_miss <= 1'b0;
            end else begin
                if (state_q == DONE && frame_q == FRAME_LAST && tx_busy)
                    overrun <= 1'b1;
                if (pcm_stb && state_q != IDLE)
                    stb_miss <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pcm_packetizer.sv
// tb/tb_pcm_packetizer.sv - self-checking bench for pcm_packetizer
module tb_pcm_packetizer;
    localparam int CH = 12, SW = 16, FR = 32, HDR = 14, AW = 11;
    localparam int B = SW / 8, FB = CH * B, BANK = 1 << (AW - 1);
`ifdef PCM_PACKETIZER_SEQ_EN
    localparam int S = 2;
    localparam int TXLEN_LIT = 784;
    localparam int TXLEN2_LIT = 40;
`else
    localparam int S = 0;
    localparam int TXLEN_LIT = 782;
    localparam int TXLEN2_LIT = 38;
`endif

    logic clk, rst_n, pcm_stb, tx_busy, clr_flags;
    logic [CH*SW-1:0] pcm_data;
    logic wr_en, tx_start, tx_bank, overrun, stb_miss;
    logic [AW-1:0] wr_addr;
    logic [7:0] wr_data;
    logic [AW-2:0] tx_len;

    logic stb2, busy2, clr2;
    logic [47:0] data2;
    logic wr_en2, tx_start2, tx_bank2, overrun2, stb_miss2;
    logic [AW-1:0] wr_addr2;
    logic [7:0] wr_data2;
    logic [AW-2:0] tx_len2;

    pcm_packetizer dut (
        .clk(clk), .rst_n(rst_n), .pcm_stb(pcm_stb), .pcm_data(pcm_data),
        .tx_busy(tx_busy), .clr_flags(clr_flags), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .tx_start(tx_start), .tx_bank(tx_bank), .tx_len(tx_len),
        .overrun(overrun), .stb_miss(stb_miss)
    );

    pcm_packetizer #(.CHANNELS(2), .SAMPLE_W(24), .FRAMES(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .pcm_stb(stb2), .pcm_data(data2),
        .tx_busy(busy2), .clr_flags(clr2), .wr_en(wr_en2), .wr_addr(wr_addr2),
        .wr_data(wr_data2), .tx_start(tx_start2), .tx_bank(tx_bank2), .tx_len(tx_len2),
        .overrun(overrun2), .stb_miss(stb_miss2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int addr; int data; } wr_t;
    typedef struct { int cyc; int bank; } tx_t;
    wr_t wq[$];
    tx_t tq[$];
    int m_fill, m_frame, m_seq, m_next_ok;
    int checks = 0, errors = 0;
    int n_tx = 0, n_tx2 = 0, first_addr = -1;
    bit grab_first = 1'b0;
    logic [7:0] mem [0:2047];
    logic [7:0] mem2 [0:2047];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: expected writes/tx pulses derived from strobe time and the packet layout rules.
    task automatic compare_cycle();
        while (wq.size() > 0 && wq[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL write_missing cyc %0d: expected addr %0d data %02h", wq[0].cyc, wq[0].addr, wq[0].data);
            void'(wq.pop_front());
        end
        if (wq.size() > 0 && wq[0].cyc == cyc) begin
            checks++;
            if (wr_en !== 1'b1 || int'(wr_addr) != wq[0].addr || int'(wr_data) != wq[0].data) begin
                errors++;
                $display("FAIL write cyc %0d: got en=%0b addr=%0d data=%02h expected addr=%0d data=%02h",
                         cyc, wr_en, wr_addr, wr_data, wq[0].addr, wq[0].data);
            end
            void'(wq.pop_front());
        end else if (wr_en !== 1'b0) begin
            checks++; errors++;
            $display("FAIL unexpected_write cyc %0d: got addr=%0d expected no write", cyc, wr_addr);
        end
        while (tq.size() > 0 && tq[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL tx_start_missing cyc %0d: expected bank %0d", tq[0].cyc, tq[0].bank);
            void'(tq.pop_front());
        end
        if (tq.size() > 0 && tq[0].cyc == cyc) begin
            checks++;
            if (tx_start !== 1'b1 || int'(tx_bank) != tq[0].bank) begin
                errors++;
                $display("FAIL tx_start cyc %0d: got start=%0b bank=%0b expected 1/%0d", cyc, tx_start, tx_bank, tq[0].bank);
            end
            void'(tq.pop_front());
        end else if (tx_start !== 1'b0) begin
            checks++; errors++;
            $display("FAIL unexpected_tx_start cyc %0d: got 1 expected 0", cyc);
        end
        if (wr_en) begin
            mem[wr_addr] = wr_data;
            if (grab_first) begin first_addr = int'(wr_addr); grab_first = 1'b0; end
        end
        if (tx_start) n_tx++;
        if (wr_en2) mem2[wr_addr2] = wr_data2;
        if (tx_start2) n_tx2++;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send(input logic [CH*SW-1:0] d);
        int t, w, base;
        logic [CH*SW-1:0] sh;
        @(posedge clk); #1;
        pcm_stb = 1'b1;
        pcm_data = d;
        t = cyc + 1;
        if (t >= m_next_ok) begin
            base = m_fill * BANK;
            w = 0;
            if (S == 2 && m_frame == 0) begin
                wq.push_back('{t, base + HDR, m_seq & 255});
                wq.push_back('{t + 1, base + HDR + 1, (m_seq >> 8) & 255});
                w = 2;
            end
            for (int c = 0; c < CH; c++) begin
                for (int k = 0; k < B; k++) begin
                    sh = d >> (c * SW + 8 * k);
                    wq.push_back('{t + w, base + HDR + S + m_frame * FB + c * B + k, int'(sh[7:0])});
                    w++;
                end
            end
            m_next_ok = t + w + 2;
            m_frame++;
            if (m_frame == FR) begin
                m_frame = 0;
                m_seq = (m_seq + 1) & 16'hFFFF;
                if (!tx_busy) begin
                    tq.push_back('{t + w + 1, m_fill});
                    m_fill ^= 1;
                end
            end
        end
        @(posedge clk); #1;
        pcm_stb = 1'b0;
    endtask

    function automatic logic [CH*SW-1:0] pat(input int p, input int f);
        logic [CH*SW-1:0] r;
        for (int c = 0; c < CH; c++) r[c*SW +: SW] = 16'((c << 8) + f + p * 16'h0A51);
        return r;
    endfunction

    task automatic run_packet(input int p, input int f0);
        int f;
        f = f0;
        do begin
            send(pat(p, f));
            f++;
            idle(28);
        end while (m_frame != 0);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr_flags = 1'b1;
        @(posedge clk); #1 clr_flags = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) begin mem[i] = 8'h00; mem2[i] = 8'h00; end
        rst_n = 1'b0; pcm_stb = 1'b0; pcm_data = '0; tx_busy = 1'b0; clr_flags = 1'b0;
        stb2 = 1'b0; data2 = '0; busy2 = 1'b0; clr2 = 1'b0;
        m_fill = 0; m_frame = 0; m_seq = 0; m_next_ok = 0;
        fork
            forever begin @(negedge clk); compare_cycle(); end
        join_none
        idle(3); #1;
        chk("reset_wr_en", wr_en, 0);
        chk("reset_wr_addr", wr_addr, 0);
        chk("reset_tx_start", tx_start, 0);
        chk("reset_flags", {overrun, stb_miss, tx_bank}, 0);
        chk("tx_len", tx_len, TXLEN_LIT);
        chk("tx_len2", tx_len2, TXLEN2_LIT);
        rst_n = 1'b1;

        // Small configuration: 2 channels of 24 bits, 4 frames.
        for (int f = 0; f < 4; f++) begin
            @(posedge clk); #1;
            stb2 = 1'b1; data2 = {24'hABCDE0 + 24'(f), 24'h123450 + 24'(f)};
            @(posedge clk); #1 stb2 = 1'b0;
            idle(10);
        end
        idle(4);
        chk("cfg2_b0", mem2[HDR+S+0], 8'h50);
        chk("cfg2_b1", mem2[HDR+S+1], 8'h34);
        chk("cfg2_b2", mem2[HDR+S+2], 8'h12);
        chk("cfg2_b3", mem2[HDR+S+3], 8'hE0);
        chk("cfg2_b5", mem2[HDR+S+5], 8'hAB);
        chk("cfg2_f3_b0", mem2[HDR+S+18], 8'h53);
        chk("cfg2_last", mem2[HDR+S+23], 8'hAB);
        chk("cfg2_tx", n_tx2, 1);

        // Packet 1: channel c = 0x0100*c + frame, into bank 0.
        run_packet(0, 0);
        idle(4);
`ifdef PCM_PACKETIZER_SEQ_EN
        chk("p1_seq_lo", mem[14], 8'h00);
        chk("p1_seq_hi", mem[15], 8'h00);
`endif
        chk("p1_ch0_lo", mem[HDR+S], 8'h00);
        chk("p1_ch0_hi", mem[HDR+S+1], 8'h00);
        chk("p1_ch1_hi", mem[HDR+S+3], 8'h01);
        chk("p1_f5_ch0", mem[HDR+S+5*FB], 8'h05);
        chk("p1_tx_count", n_tx, 1);
        chk("p1_tx_bank", tx_bank, 0);

        // Packet 2: close strobes get dropped; transmitter busy at the end.
        tx_busy = 1'b1;
        grab_first = 1'b1;
        send(pat(1, 0)); idle(8);
        send(pat(1, 1)); idle(8);
        send(pat(1, 2));
        chk("stb_miss_set", stb_miss, 1);
        idle(28);
        run_packet(1, 3);
        idle(4);
        chk("p2_bank1", first_addr, BANK + HDR);
`ifdef PCM_PACKETIZER_SEQ_EN
        chk("p2_seq", mem[BANK+14], 8'h01);
`endif
        chk("overrun_set", overrun, 1);
        chk("p2_no_tx", n_tx, 1);
        pulse_clr();
        chk("clr_stb_miss", stb_miss, 0);
        chk("clr_overrun", overrun, 0);
        tx_busy = 1'b0;

        // Packet 3 reuses bank 1 after the overrun.
        run_packet(2, 0);
        idle(4);
`ifdef PCM_PACKETIZER_SEQ_EN
        chk("p3_seq", mem[BANK+14], 8'h02);
`endif
        chk("p3_tx_count", n_tx, 2);
        chk("p3_tx_bank", tx_bank, 1);

`ifdef PCM_PACKETIZER_SEQ_EN
        force dut.seq_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.seq_q;
        m_seq = 16'hFFFF;
`endif
        run_packet(3, 0);
        run_packet(4, 0);
        idle(4);
`ifdef PCM_PACKETIZER_SEQ_EN
        chk("wrap_seq_lo", mem[14], 8'hFF);
        chk("wrap_seq_hi", mem[15], 8'hFF);
        chk("after_wrap_lo", mem[BANK+14], 8'h00);
        chk("after_wrap_hi", mem[BANK+15], 8'h00);
`endif
        chk("p5_tx_bank", tx_bank, 1);

        // Reset in the middle of frame 5.
        for (int f = 0; f < 5; f++) begin send(pat(5, f)); idle(28); end
        send(pat(5, 5));
        idle(4);
        #3 rst_n = 1'b0;
        #1;
        chk("async_wr_en", wr_en, 0);
        chk("async_wr_addr", wr_addr, 0);
        chk("async_wr_data", wr_data, 0);
        chk("async_other", {tx_start, tx_bank, overrun, stb_miss}, 0);
        wq.delete(); tq.delete();
        m_fill = 0; m_frame = 0; m_seq = 0; m_next_ok = 0;
        idle(2); #1 rst_n = 1'b1;
        grab_first = 1'b1;
        send(pat(6, 0));
        idle(30);
        chk("rst_first_addr", first_addr, HDR);
`ifdef PCM_PACKETIZER_SEQ_EN
        chk("rst_seq_lo", mem[14], 8'h00);
        chk("rst_seq_hi", mem[15], 8'h00);
`endif
        chk("pending_model", wq.size() + tq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pcm_packetizer.md
# pcm_packetizer

Parametrised PCM-to-frame-buffer packetizer between the audio filter bank and the Ethernet transmitter. Each PCM strobe snapshots all channel samples and writes them byte-serially into one half of a ping-pong BRAM frame buffer. After a programmable number of sample frames it hands that half to the transmitter and continues filling the other half, so capture never stalls during transmission. Adds an optional packet sequence number plus sticky overrun and missed-strobe flags.

## Interface
- CHANNELS, 12, number of PCM channels per frame (1..32)
- SAMPLE_W, 16, bits per sample; multiple of 8; B = SAMPLE_W/8 bytes per sample
- FRAMES, 32, sample frames per packet
- HDR_BYTES, 14, bytes reserved at start of each bank for the Ethernet header (not written here)
- ADDR_W, 11, BRAM byte-address width; bank size is 2^(ADDR_W-1); the MSB selects the bank
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pcm_stb  in  1  one-cycle strobe: new samples valid on pcm_data
- pcm_data  in  CHANNELS*SAMPLE_W  channel c at bits [c*SAMPLE_W +: SAMPLE_W], two's complement
- tx_busy  in  1  transmitter is reading a bank
- clr_flags  in  1  one-cycle pulse, clears overrun and stb_miss
- wr_en  out  1  BRAM write enable
- wr_addr  out  ADDR_W  BRAM byte address
- wr_data  out  8  BRAM write byte
- tx_start  out  1  one-cycle pulse: bank tx_bank holds a complete packet
- tx_bank  out  1  bank to transmit; stable from tx_start until the next tx_start
- tx_len  out  ADDR_W-1  constant packet length in bytes: HDR_BYTES + S + FRAMES*CHANNELS*B (S = 2 with sequence, else 0)
- overrun  out  1  sticky: packet completed while tx_busy high
- stb_miss  out  1  sticky: pcm_stb arrived outside IDLE

## Operation
- States: IDLE, SEQ, DATA, DONE.
- IDLE: on pcm_stb, register all of pcm_data into a snapshot; go to SEQ if frame counter is 0 and the sequence number is compiled in, else DATA.
- SEQ: two writes, seq[7:0] then seq[15:8], at bank offsets HDR_BYTES and HDR_BYTES+1.
- DATA: one byte per cycle, channel 0 first, each sample LSB byte first; CHANNELS*B writes. Byte offset = HDR_BYTES + S + frame*CHANNELS*B + c*B + k.
- wr_addr = {fill_bank, offset}; wr_data from the snapshot only, never live pcm_data.
- DONE (one cycle): frame counter increments. If the incremented value equals FRAMES:
  - frame counter returns to 0.
  - tx_busy low: pulse tx_start, tx_bank <= fill_bank, fill_bank toggles, seq increments (16-bit wrap 0xFFFF -> 0).
  - tx_busy high: set overrun, no tx_start, fill_bank unchanged (the packet is overwritten), seq still increments, so the receiver sees the gap.
- Return to IDLE.
- pcm_stb in SEQ/DATA/DONE: ignored, stb_miss set.
- clr_flags takes priority over a same-cycle set (clear wins).
- Elaboration check: tx_len must not exceed 2^(ADDR_W-1); violation is a $error.

## Timing
- Reset (async assert, sync release): all outputs 0, state IDLE, fill_bank 0, frame counter 0, seq 0.
- pcm_stb at cycle N: snapshot at N+1. The first wr_en=1 appears at N+1 (registered outputs). The W write cycles are contiguous, with W = CHANNELS*B (+2 on frame 0 with sequence).
- DONE lies one cycle after the last write; wr_en is 0 in DONE. tx_start is asserted in the cycle after DONE, for exactly one cycle. IDLE then accepts pcm_stb.
- Minimum strobe spacing without a miss: W+2 cycles.
- tx_busy is sampled only in DONE.
- Reset mid-packet: the partial packet is abandoned, no tx_start, writing restarts in bank 0 with seq 0.

## Configuration
- PCM_PACKETIZER_SEQ_EN defined: 16-bit little-endian sequence number at offset HDR_BYTES of every packet; S = 2.
- Not defined: the SEQ state and seq counter are absent, samples start at offset HDR_BYTES, S = 0, and tx_len shrinks by 2.

## Test plan
- Defaults with SEQ_EN: 32 strobes with channel c = 0x0100*c + frame. Required:
  - bank 0 bytes 14,15 = 00,00
  - byte 16 = 0x00 and byte 17 = 0x00 (ch0, frame 0)
  - tx_start is a single pulse with tx_bank=0 and tx_len=784
  - the next packet goes to bank 1 (wr_addr ≥ 1024) with seq = 1.
- Strobe spacing 10 cycles with CHANNELS=12 gives stb_miss=1, and missed frames are not written. clr_flags then gives stb_miss=0 on the next cycle.
- tx_busy held high at the end of packet 2 gives:
  - overrun=1 and no tx_start
  - the next packet is written to the same bank with seq = 2.
- Seq preset via force to 0xFFFF: the packet carries FF,FF and the following packet carries 00,00.
- rst_n pulled low during frame 5: all outputs are 0 immediately (asynchronous). After release, the first write address is 14 in bank 0 and seq is 0.
- Without SEQ_EN, CHANNELS=2, SAMPLE_W=24, FRAMES=4: tx_len = 14+24 = 38, and sample bytes are written at offsets 14..37, LSB first.
